// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 serial pattern detector.
// No logic; constants only.
// No flow control; constants only.
package seq_det_pkg;

  // FSM state encoding; the value of a partial-match state is the number of
  // pattern bits matched so far.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S10   = 3'd2;
  localparam logic [2:0] S101  = 3'd3;
  localparam logic [2:0] S1011 = 3'd4;

  // Pattern, MSB received first.
  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: new value visible one cycle after inc/clr.
// No backpressure; clr overrides inc, and the count holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stop at all-ones, clear takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1011 with a saturating match counter.
// Latency: detect/count update on the edge that samples the final 1.
// No backpressure; en=0 freezes state, detect and count; clr wins over en.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  output logic             detect,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  logic [2:0] state_q;
  logic [2:0] next_state;
  logic       hit_inc;

  // Next state from the current partial match and the incoming bit.
  always_comb begin
    next_state = IDLE;
    case (state_q)
      IDLE:  next_state = (din == PATTERN[3]) ? S1   : IDLE;
      S1:    next_state = (din == PATTERN[2]) ? S10  : S1;
      S10:   next_state = (din == PATTERN[1]) ? S101 : IDLE;
      S101:  next_state = (din == PATTERN[0]) ? S1011 : S10;
      // After a full match, a trailing 1 always restarts a new prefix; a
      // trailing 0 keeps the "10" suffix only when matches may overlap.
      S1011: begin
        if (din) begin
          next_state = S1;
        end else begin
          next_state = (OVERLAP != 0) ? S10 : IDLE;
        end
      end
      // Unreachable encodings recover to IDLE.
      default: next_state = IDLE;
    endcase
  end

  // State register: clear beats enable, disabled edges hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (clr) begin
      state_q <= IDLE;
    end else if (en) begin
      state_q <= next_state;
    end
  end

  // A match is counted on the enabled edge that enters S1011; the counter's
  // own clr priority drops a match that coincides with a clear.
  assign hit_inc = en && (next_state == S1011);

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (hit_inc),
    .q     (count)
  );

  assign detect = (state_q == S1011);
  assign state  = state_q;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Self-checking bench for seq_detector_1011: three instances (overlap,
// non-overlap, 2-bit counter) share the stimulus and are compared every cycle
// against a bit-history reference model.
module tb_seq_detector_1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       en;
  logic       clr;

  logic       det_ov, det_no, det_sat;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;
  logic [2:0] st_ov, st_no, st_sat;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one slot per DUT instance.
  logic [3:0] m_win   [3];
  int         m_nb    [3];
  bit         m_det   [3];
  int         m_cnt   [3];
  int         pulses  [3];
  int         m_ovl   [3] = '{1, 0, 1};
  int         m_max   [3] = '{255, 255, 3};
  logic [3:0] pat = 4'b1011;

  seq_detector_1011 #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .din(din), .en(en), .clr(clr),
    .detect(det_ov), .count(cnt_ov), .state(st_ov)
  );

  seq_detector_1011 #(.OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .din(din), .en(en), .clr(clr),
    .detect(det_no), .count(cnt_no), .state(st_no)
  );

  seq_detector_1011 #(.OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .din(din), .en(en), .clr(clr),
    .detect(det_sat), .count(cnt_sat), .state(st_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_win[i] = '0;
      m_nb[i]  = 0;
      m_det[i] = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  // Expected state = length of the longest received suffix that is a prefix
  // of the pattern, or 4 while a match is being shown.
  function automatic int exp_state(input int i);
    bit ok;
    if (m_det[i]) return 4;
    for (int k = 3; k >= 1; k--) begin
      if (m_nb[i] >= k) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (m_win[i][j] != pat[4-k+j]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_edge(input logic d, input logic e, input logic c);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        m_win[i] = '0;
        m_nb[i]  = 0;
        m_det[i] = 1'b0;
        m_cnt[i] = 0;
      end else if (e) begin
        m_win[i] = {m_win[i][2:0], d};
        m_nb[i]++;
        if (m_nb[i] >= 4 && m_win[i] == pat) begin
          m_det[i] = 1'b1;
          if (m_cnt[i] < m_max[i]) m_cnt[i]++;
          if (m_ovl[i] == 0) m_nb[i] = 0;
        end else begin
          m_det[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic d, input logic e, input logic c);
    int od [3];
    int oc [3];
    int os [3];
    @(negedge clk);
    din = d;
    en  = e;
    clr = c;
    @(posedge clk);
    model_edge(d, e, c);
    #1;
    od = '{int'(det_ov), int'(det_no), int'(det_sat)};
    oc = '{int'(cnt_ov), int'(cnt_no), int'(cnt_sat)};
    os = '{int'(st_ov), int'(st_no), int'(st_sat)};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("detect[%0d]", i), od[i], int'(m_det[i]));
      chk($sformatf("count[%0d]", i), oc[i], m_cnt[i]);
      chk($sformatf("state[%0d]", i), os[i], exp_state(i));
      if (e && !c && od[i] != 0) pulses[i]++;
    end
  endtask

  // Pulse reset between edges and check it acts without a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_state_ov", int'(st_ov), 0);
    chk("rst_state_no", int'(st_no), 0);
    chk("rst_det_ov", int'(det_ov), 0);
    chk("rst_cnt_ov", int'(cnt_ov), 0);
    chk("rst_cnt_sat", int'(cnt_sat), 0);
    model_reset();
    reset = 1'b0;
  endtask

  int bits   [7] = '{1, 0, 1, 1, 0, 1, 1};
  int ov_det [7] = '{0, 0, 0, 1, 0, 0, 1};
  int no_det [7] = '{0, 0, 0, 1, 0, 0, 0};
  int lead   [7] = '{1, 1, 1, 1, 0, 1, 1};
  int sat_exp[5] = '{1, 2, 3, 3, 3};
  int pat_bits[6] = '{1, 0, 1, 1, 0, 0};

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    #1;
    chk("init_state", int'(st_ov), 0);
    chk("init_det", int'(det_ov), 0);
    chk("init_cnt", int'(cnt_ov), 0);
    #2;
    reset = 1'b0;

    // Overlap vs non-overlap on 1011011.
    for (int i = 0; i < 7; i++) begin
      step(bits[i][0], 1'b1, 1'b0);
      chk($sformatf("ov_det_e%0d", i + 1), int'(det_ov), ov_det[i]);
      chk($sformatf("no_det_e%0d", i + 1), int'(det_no), no_det[i]);
      if (i == 4) chk("ov_state_e5", int'(st_ov), 2);
    end
    chk("ov_count", int'(cnt_ov), 2);
    chk("no_count", int'(cnt_no), 1);
    chk("no_state_e7", int'(st_no), 1);

    // Walk into S101, then reset between edges.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ov_in_s101", int'(st_ov), 3);
    async_reset();

    // Clear on the edge that would complete a match.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_state", int'(st_ov), 0);
    chk("clr_det", int'(det_ov), 0);
    chk("clr_cnt", int'(cnt_ov), 0);

    // Leading ones: only the tail completes a match.
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    for (int i = 0; i < 7; i++) step(lead[i][0], 1'b1, 1'b0);
    chk("lead_pulses", pulses[0], 1);
    chk("lead_det", int'(det_ov), 1);
    chk("lead_cnt", int'(cnt_ov), 1);

    // Enable gating: hold in S10 while din toggles, then complete.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b0, 1'b0);
      chk("gap_state", int'(st_ov), 2);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("gate_det", int'(det_ov), 1);
    chk("gate_cnt", int'(cnt_ov), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("gate_det_hold", int'(det_ov), 1);

    // Saturation of the 2-bit counter over five separated matches.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    for (int m = 0; m < 5; m++) begin
      for (int b = 0; b < 6; b++) begin
        step(pat_bits[b][0], 1'b1, 1'b0);
        if (b == 3) begin
          chk($sformatf("sat_cnt_m%0d", m + 1), int'(cnt_sat), sat_exp[m]);
          chk($sformatf("sat_det_m%0d", m + 1), int'(det_sat), 1);
        end
      end
    end
    chk("sat_pulses", pulses[2], 5);

    // Random traffic, biased towards ones, with occasional clr and reset.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        async_reset();
      end else begin
        step(logic'($urandom_range(0, 99) < 60),
             logic'($urandom_range(0, 99) < 85),
             logic'($urandom_range(0, 99) < 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
